lc2k_fetch_unit: RTL and testbench

LC2K_FETCH_UNIT -- requirements
Module: lc2k_fetch_unit

---
 rtl/lc2k_fetch_unit_if.sv | 29 ++
 rtl/lc2k_fetch_unit.sv | 115 +++++++++++
 tb/tb_lc2k_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lc2k_fetch_unit_if.sv
// Bus bundle between the LC2K fetch unit, instruction memory and the control stage.
// The master modport is the fetch unit's view; slave is the memory/control side.
interface lc2k_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [2:0]  opcode;
    logic [31:0] pcCurrent;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, opcode, pcCurrent,
               halted, retired_count,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, opcode, pcCurrent,
               halted, retired_count,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/lc2k_fetch_unit.sv
// LC2K instruction fetch: request/ack fetch, valid/ready issue, redirect and HALT handling.
// Optional retired-instruction counter enabled by defining FETCH_RETIRE_COUNT_EN.
module lc2k_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    lc2k_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pccur_q, pccur_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        retire;

    assign retire = (state_q == ISSUE) && valid_q && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pccur_q  <= RESET_PC;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pccur_q  <= pccur_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Every output is a register; this block only computes their next values.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pccur_d  = pccur_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pccur_d = pc_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (retire) begin
                    valid_d = 1'b0;
                    if (instr_q[24:22] == 3'b110) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        // Redirect is only meaningful at the moment of retire.
                        pc_d    = bus.redirect ? bus.redirect_pc : pc_q + 32'd1;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            HALTED: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instruction = instr_q;
    assign bus.opcode      = instr_q[24:22];
    assign bus.pcCurrent   = pccur_q;
    assign bus.halted      = halted_q;

`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= 32'd0;
        else if (retire)
            count_q <= count_q + 32'd1;
    end

    assign bus.retired_count = count_q;
`else
    assign bus.retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Randomized self-checking bench for lc2k_fetch_unit against a transaction-level PC model.
module tb_lc2k_fetch_unit;

    logic clk;
    logic rst_n;

    lc2k_fetch_unit_if bus ();

    lc2k_fetch_unit #(.RESET_PC(32'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_halted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_cnt();
`ifdef FETCH_RETIRE_COUNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_reset_values();
        chk("rst_req",    {31'd0, bus.imem_req},    32'd0);
        chk("rst_addr",   bus.imem_addr,            32'd0);
        chk("rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr",  bus.instruction,          32'd0);
        chk("rst_opcode", {29'd0, bus.opcode},      32'd0);
        chk("rst_pccur",  bus.pcCurrent,            32'd0);
        chk("rst_halted", {31'd0, bus.halted},      32'd0);
        chk("rst_count",  bus.retired_count,        32'd0);
    endtask

    // Entered one cycle into REQ; fetches, holds, then retires one instruction.
    task automatic fetch_one(input logic [2:0] op, input logic redir, input logic [31:0] rpc,
                             input int ack_dly, input int rdy_dly);
        logic [31:0] word;
        word = $urandom;
        word[24:22] = op;
        chk("req_on",   {31'd0, bus.imem_req},    32'd1);
        chk("req_addr", bus.imem_addr,            exp_pc);
        chk("req_nval", {31'd0, bus.instr_valid}, 32'd0);
        for (int i = 0; i < ack_dly; i++) begin
            bus.redirect    = $urandom_range(0, 1);
            bus.redirect_pc = $urandom;
            bus.instr_ready = $urandom_range(0, 1);
            step();
            chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
            chk("addr_hold", bus.imem_addr, exp_pc);
        end
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = word;
        bus.instr_ready = $urandom_range(0, 1);
        bus.redirect    = 1'b0;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        bus.instr_ready = 1'b0;
        chk("iss_valid",  {31'd0, bus.instr_valid}, 32'd1);
        chk("iss_req",    {31'd0, bus.imem_req},    32'd0);
        chk("iss_instr",  bus.instruction,          word);
        chk("iss_opcode", {29'd0, bus.opcode},      {29'd0, op});
        chk("iss_pccur",  bus.pcCurrent,            exp_pc);
        for (int i = 0; i < rdy_dly; i++) begin
            bus.imem_ack   = $urandom_range(0, 1);
            bus.imem_rdata = $urandom;
            step();
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_instr", bus.instruction,          word);
            chk("stall_pccur", bus.pcCurrent,            exp_pc);
            chk("stall_req",   {31'd0, bus.imem_req},    32'd0);
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        step();
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        if (op == 3'b110) exp_halted = 1'b1;
        else              exp_pc = redir ? rpc : exp_pc + 32'd1;
        chk("ret_nval",   {31'd0, bus.instr_valid}, 32'd0);
        chk("ret_halted", {31'd0, bus.halted},      {31'd0, exp_halted});
        chk("ret_req",    {31'd0, bus.imem_req},    {31'd0, ~exp_halted});
        chk("ret_count",  bus.retired_count,        model_cnt());
        if (!exp_halted) chk("ret_addr", bus.imem_addr, exp_pc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_pc = 32'd0;
        exp_cnt = 32'd0;
        exp_halted = 1'b0;
        check_reset_values();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [2:0]  op;
        logic        rd;
        logic [31:0] rpc;
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        exp_pc = 32'd0; exp_cnt = 32'd0; exp_halted = 1'b0;
        step();
        step();
        do_reset();

        // Three ADDs in sequence, then a redirected retire and a wrap past 32'hFFFFFFFF.
        fetch_one(3'b000, 1'b0, 32'd0, 2, 0);
        fetch_one(3'b000, 1'b0, 32'd0, 0, 0);
        fetch_one(3'b000, 1'b0, 32'd0, 1, 0);
        chk("seq_addr", bus.imem_addr, 32'd3);
        fetch_one(3'b100, 1'b1, 32'h10, 3, 5);
        chk("redir_addr", bus.imem_addr, 32'h10);
        fetch_one(3'b101, 1'b1, 32'hFFFF_FFFF, 1, 2);
        fetch_one(3'b001, 1'b0, 32'h1234, 0, 1);
        chk("wrap_addr", bus.imem_addr, 32'd0);

        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(0, 7));
            if (op == 3'b110) op = 3'b111;
            rd  = ($urandom_range(0, 3) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            fetch_one(op, rd, rpc, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // HALT: no further requests, even with stray acks.
        fetch_one(3'b110, 1'b0, 32'd0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack    = $urandom_range(0, 1);
            bus.instr_ready = $urandom_range(0, 1);
            step();
            chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
        end
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        step();
        do_reset();
        fetch_one(3'b000, 1'b0, 32'd0, 1, 0);

        // Reset while a request is pending; a late ack must not be taken.
        chk("pend_req", {31'd0, bus.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_addr", bus.imem_addr, 32'd0);
        exp_pc = 32'd0; exp_cnt = 32'd0; exp_halted = 1'b0;
        step();
        rst_n = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        chk("late_ack_nval", {31'd0, bus.instr_valid}, 32'd0);
        chk("late_ack_req",  {31'd0, bus.imem_req},    32'd1);
        chk("late_ack_addr", bus.imem_addr,            32'd0);
        fetch_one(3'b010, 1'b0, 32'd0, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
